// File: rtl/btree_sched.sv
// btree_sched: reduces one buffered set of N operands through a single shared
// two-input operator, pairing partials level by level, and returns the result.
module btree_sched #(
  parameter int WIDTH = 32,
  parameter int N     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH*N-1:0] in_data,
  output logic               op_req,
  input  logic               op_gnt,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  input  logic [WIDTH-1:0]   op_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int AW     = $clog2(N);
  localparam int LEVELS = $clog2(N);
  localparam int LW     = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int IW     = (N > 2) ? $clog2(N / 2) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] opnd_r [N];
  logic [LW-1:0]    lvl_r;
  logic [IW-1:0]    idx_r;
  logic             in_ready_r;
  logic             op_req_r;
  logic             out_valid_r;

  logic [IW-1:0]    last_idx_s;
  logic             lvl_end_s;
  logic             final_s;
  logic [AW-1:0]    rd_a_s;
  logic [AW-1:0]    rd_b_s;
  logic [AW-1:0]    wr_s;

  // Pair addressing and end-of-level / end-of-tree detection.
  always_comb begin
    last_idx_s = IW'((N >> (int'(lvl_r) + 32'sd1)) - 32'sd1);
    lvl_end_s  = (idx_r == last_idx_s);
    final_s    = lvl_end_s && (lvl_r == LW'(LEVELS - 1));
    rd_a_s     = AW'({idx_r, 1'b0});
    rd_b_s     = AW'({idx_r, 1'b1});
    wr_s       = AW'(idx_r);
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = REDUCE;
        else          state_nxt_s = IDLE;
      end
      REDUCE: begin
        if (op_gnt && final_s) state_nxt_s = DONE;
        else                   state_nxt_s = REDUCE;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      op_req_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      op_req_r    <= (state_nxt_s == REDUCE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand buffer and level/pair counters; partials overwrite slot idx in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) opnd_r[i] <= {WIDTH{1'b0}};
      lvl_r <= {LW{1'b0}};
      idx_r <= {IW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) opnd_r[i] <= in_data[WIDTH*i +: WIDTH];
            lvl_r <= {LW{1'b0}};
            idx_r <= {IW{1'b0}};
          end
        end
        REDUCE: begin
          if (op_gnt) begin
            opnd_r[wr_s] <= op_res;
            if (lvl_end_s) begin
              idx_r <= {IW{1'b0}};
              lvl_r <= lvl_r + 1'b1;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign op_req    = op_req_r;
  assign out_valid = out_valid_r;
  assign op_a      = opnd_r[rd_a_s];
  assign op_b      = opnd_r[rd_b_s];
  assign out_data  = opnd_r[0];

endmodule

// File: tb/tb_btree_sched.sv
// Self-checking bench for btree_sched: vector table, directed corner cases and
// randomized sets checked against a level-by-level reduction model.
module tb_btree_sched;

  localparam int WIDTH = 32;
  localparam int N     = 8;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [WIDTH*N-1:0] set_t;
  typedef struct packed {
    set_t  data;
    logic  sub;
    word_t exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  set_t         in_data;
  logic         op_req;
  logic         op_gnt;
  word_t        op_a;
  word_t        op_b;
  word_t        op_res;
  logic         out_valid;
  logic         out_ready;
  word_t        out_data;
  logic         op_sub;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign op_res = op_sub ? (op_a - op_b) : (op_a + op_b);

  btree_sched #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op_req    (op_req),
    .op_gnt    (op_gnt),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_res    (op_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic set_t pack8(input word_t a0, input word_t a1, input word_t a2, input word_t a3,
                                 input word_t a4, input word_t a5, input word_t a6, input word_t a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Presents one set, drives grants, checks every node issued and the result.
  task automatic run_set(input set_t data, input logic sub, input bit use_exp, input word_t exp_in,
                         input int duty, input int bp, input bit keep_valid, output int acc_cyc);
    word_t lv[$];
    word_t nx[$];
    word_t pa[$];
    word_t pb[$];
    word_t exp_res;
    int    withheld;
    int    t;
    bit    gnt;
    for (int i = 0; i < N; i++) lv.push_back(data[WIDTH*i +: WIDTH]);
    while (lv.size() > 1) begin
      nx = {};
      for (int i = 0; i < lv.size(); i += 2) begin
        pa.push_back(lv[i]);
        pb.push_back(lv[i+1]);
        nx.push_back(sub ? (lv[i] - lv[i+1]) : (lv[i] + lv[i+1]));
      end
      lv = nx;
    end
    exp_res = use_exp ? exp_in : lv[0];

    op_sub   = sub;
    in_data  = data;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", word_t'(in_ready), 32'd1);
    out_ready = 1'b0;
    acc_cyc = cyc;
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;

    withheld = 0;
    t = 0;
    while (!out_valid && t < 200) begin
      chk("op_req", word_t'(op_req), 32'd1);
      if (pa.size() > 0) begin
        chk("op_a", op_a, pa[0]);
        chk("op_b", op_b, pb[0]);
        gnt = ($urandom_range(0, 99) < duty);
      end else begin
        gnt = 1'b0;
      end
      op_gnt = gnt;
      if (gnt) begin
        void'(pa.pop_front());
        void'(pb.pop_front());
      end else begin
        withheld++;
      end
      @(negedge clk);
      t++;
    end
    op_gnt = 1'b0;
    chk("out_valid", word_t'(out_valid), 32'd1);
    chk("latency", word_t'(cyc - acc_cyc), word_t'(N + withheld));
    chk("nodes_left", word_t'(pa.size()), 32'd0);
    chk("out_data", out_data, exp_res);
    chk("in_ready_done", word_t'(in_ready), 32'd0);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_out_valid", word_t'(out_valid), 32'd1);
      chk("bp_out_data", out_data, exp_res);
      chk("bp_in_ready", word_t'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
  endtask

  // Completes the output handshake and checks the return to idle.
  task automatic finish_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_in_ready", word_t'(in_ready), 32'd1);
    chk("post_out_valid", word_t'(out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vecs [6];
    set_t ramp;
    set_t ones;
    set_t rs;
    int   acc0;
    int   acc1;
    logic s;

    ramp = pack8(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    ones = {N{32'hFFFF_FFFF}};
    vecs[0] = '{data: ramp, sub: 1'b0, exp: 32'd36};
    vecs[1] = '{data: pack8(32'd8, 32'd4, 32'd2, 32'd1, 32'd16, 32'd8, 32'd4, 32'd2),
                sub: 1'b1, exp: 32'hFFFF_FFFD};
    vecs[2] = '{data: ones, sub: 1'b0, exp: 32'hFFFF_FFF8};
    vecs[3] = '{data: {N{32'd0}}, sub: 1'b0, exp: 32'd0};
    vecs[4] = '{data: pack8(32'd100, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1),
                sub: 1'b1, exp: 32'd99};
    vecs[5] = '{data: pack8(32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80),
                sub: 1'b0, exp: 32'd360};

    rst = 1'b1; in_valid = 1'b0; in_data = {N{32'd0}};
    op_gnt = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", word_t'(in_ready), 32'd1);
    chk("rst_op_req", word_t'(op_req), 32'd0);
    chk("rst_out_valid", word_t'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_set(vecs[i].data, vecs[i].sub, 1'b1, vecs[i].exp, 100, 0, 1'b0, acc0);
      finish_out();
    end

    // Grant gaps and output backpressure.
    run_set(ramp, 1'b0, 1'b1, 32'd36, 60, 0, 1'b0, acc0);
    finish_out();
    run_set(ramp, 1'b0, 1'b1, 32'd36, 100, 5, 1'b0, acc0);
    finish_out();

    // Back-to-back sets with in_valid held high.
    run_set(ramp, 1'b0, 1'b1, 32'd36, 100, 0, 1'b1, acc0);
    run_set(ones, 1'b0, 1'b1, 32'hFFFF_FFF8, 100, 0, 1'b1, acc1);
    chk("b2b_gap", word_t'(acc1 - acc0), 32'd9);
    in_valid = 1'b0;
    finish_out();

    // Reset in the 4th REDUCE cycle discards the partial reduction.
    chk("mid_pre_ready", word_t'(in_ready), 32'd1);
    in_data = ramp; op_sub = 1'b0; in_valid = 1'b1; op_gnt = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op_gnt = 1'b0;
    chk("mid_in_ready", word_t'(in_ready), 32'd1);
    chk("mid_out_valid", word_t'(out_valid), 32'd0);
    chk("mid_op_req", word_t'(op_req), 32'd0);
    chk("mid_out_data", out_data, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("mid_no_valid", word_t'(out_valid), 32'd0);
    end
    run_set(ramp, 1'b0, 1'b1, 32'd36, 100, 0, 1'b0, acc0);
    finish_out();

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) rs[WIDTH*i +: WIDTH] = $urandom;
      s = 1'($urandom_range(0, 1));
      run_set(rs, s, 1'b0, 32'd0, int'($urandom_range(50, 100)), int'($urandom_range(0, 3)),
              1'b0, acc0);
      finish_out();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btree_sched.md
# btree_sched

Sequencing controller for a binary-tree reduction over the 32-bit operand lanes fed to the tree pipeline. It buffers one packed set of N operands and issues the N-1 pairwise node operations level by level to a single shared two-input combinational operator. Access to that operator is arbitrated by a request/grant handshake. The reduced word is returned through a valid/ready output port, so one operator serves the whole tree instead of N-1 hardwired nodes.

## Interface
- WIDTH, 32, operand/result width in bits
- N, 8, operand count; power of two, N >= 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  controller can accept an operand set
- in_data  input  WIDTH*N  packed operands; lane i = in_data[WIDTH*i +: WIDTH]
- op_req  output  1  controller requests the shared operator
- op_gnt  input  1  operator granted this cycle
- op_a  output  WIDTH  left operand to operator
- op_b  output  WIDTH  right operand to operator
- op_res  input  WIDTH  combinational operator result, same cycle
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  reduced result

## Operation
- Storage:
  - buf[0..N-1], WIDTH-bit operand registers.
  - lvl counter, 0..log2(N)-1.
  - idx pair counter, 0..N/2-1.
  - 2-bit state.
- States:
  - IDLE: in_ready=1. On in_valid: load buf[i] <= lane i, lvl <= 0, idx <= 0, go to REDUCE.
  - REDUCE: op_req=1, op_a=buf[2*idx], op_b=buf[2*idx+1].
    - On op_gnt: buf[idx] <= op_res.
    - If idx == (N >> (lvl+1)) - 1: idx <= 0, lvl <= lvl+1. Otherwise idx <= idx+1.
    - The final operation (lvl == log2(N)-1, idx == 0) goes to DONE.
    - Without op_gnt, all state holds and op_a/op_b stay stable.
  - DONE: out_valid=1, out_data=buf[0]. On out_ready, go to IDLE.
- Operation order is fixed and non-commutative-safe. Left operand is always the lower-index partial. Level 0 pairs are (0,1),(2,3),…; level k combines adjacent level-(k-1) partials.
- Writing buf[idx] while reading buf[2*idx], buf[2*idx+1] is safe because idx <= 2*idx, and slots below idx are only read at the next level.
- No overlap: in_ready=0 in REDUCE and DONE, so a new set is accepted only from IDLE.
- op_a/op_b are don't-care when op_req=0 but are driven from buf (no X).
- The operator is never granted partially. Each granted cycle consumes exactly one node.

## Timing
- Reset state: IDLE.
  - in_ready=1, op_req=0, out_valid=0.
  - buf, lvl, idx cleared to 0, so out_data=0.
- Reset wins over every simultaneous event, including mid-REDUCE and mid-DONE. Any partial reduction is discarded and no out_valid follows.
- Input handshake cycle t: REDUCE begins at t+1.
- With op_gnt held 1:
  - N-1 REDUCE cycles.
  - out_valid first high at t+N (N=8: t+8).
  - Each cycle without grant adds exactly one cycle.
- The out_valid && out_ready cycle returns to IDLE next cycle. Minimum period between accepted sets is N+1 cycles.
- out_valid and out_data are held stable until accepted; out_data is registered.
- N=2 degenerates to a single REDUCE cycle.

## Test plan
- Reset then ramp: rst for 2 cycles, then in_data lanes 1..8, op=add, op_gnt=1. Expect:
  - Operator pairs in order (1,2),(3,4),(5,6),(7,8),(3,7),(11,15),(10,26).
  - out_valid 8 cycles after accept, out_data=36.
- Order check: op=a-b, lanes 8,4,2,1,16,8,4,2. Expect out_data = (4-1)-(8-2) = -3 (0xFFFFFFFD).
- Grant gaps: op_gnt pattern 1,0,0,1,… (random ≥50% duty), lanes 1..8, add. Expect:
  - op_a/op_b stable during every gap.
  - out_data=36.
  - Latency = 8 + number of withheld cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid. Expect out_valid/out_data held and in_ready=0 throughout. Accept → in_ready=1 next cycle.
- Back-to-back sets: in_valid held with two sets (sum 36, then lanes all 0xFFFFFFFF, sum 0xFFFFFFF8 with wraparound). Expect both results in order, accepts 9 cycles apart.
- Reset mid-operation: assert rst during the 4th REDUCE cycle. Expect:
  - Next cycle IDLE, in_ready=1, out_valid=0.
  - A fresh set afterwards reduces correctly.
